// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: checks alignment and data-region range, issues
// one memory strobe per good access, and returns extended load data on a
// valid/ready response channel.
module load_store_unit #(
  parameter logic [31:0] DATA_BEGIN = 32'h0001_0000,
  parameter logic [31:0] DATA_END   = 32'h0001_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [2:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_data_fetched
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state_q, state_d;
  logic            write_q, write_d;
  logic            unsigned_q, unsigned_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            misaligned_q, misaligned_d;
  logic            fault_q, fault_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic [2:0]      be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [1:0]      size_in;
  logic [3:0]      bytes_m1;
  logic [AW:0]     end_addr;
  logic            mis_in;
  logic            fault_in;
  logic            err_in;
  logic [DW-1:0]   raw;
  logic            ext;

  // Request checks; the end address is one bit wider so it never wraps.
  always_comb begin
    size_in  = req_funct3[1:0];
    bytes_m1 = 4'd0;
    case (size_in)
      2'b00:   bytes_m1 = 4'd0;
      2'b01:   bytes_m1 = 4'd1;
      2'b10:   bytes_m1 = 4'd3;
      default: bytes_m1 = 4'd7;
    endcase
    end_addr = {1'b0, req_address} + (AW+1)'(bytes_m1);
    mis_in   = ((size_in == 2'b01) && req_address[0]) ||
               ((size_in == 2'b10) && (req_address[1:0] != 2'b00)) ||
               ((size_in == 2'b11) && (req_address[2:0] != 3'b000));
    fault_in = (req_address < DATA_BEGIN) || (end_addr > {1'b0, DATA_END});
    err_in   = mis_in || fault_in;
  end

  // Lane extraction and sign/zero extension of the fetched word.
  always_comb begin
    raw = mem_data_fetched >> {addr_q[2:0], 3'b000};
    ext = 1'b0;
    case (be_q[1:0])
      2'b00:   ext = !unsigned_q && raw[7];
      2'b01:   ext = !unsigned_q && raw[15];
      2'b10:   ext = !unsigned_q && raw[31];
      default: ext = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d      = req_write;
          unsigned_d   = req_funct3[2];
          rdata_d      = '0;
          misaligned_d = mis_in;
          fault_d      = fault_in;
          be_d         = {1'b0, size_in};
          addr_d       = req_address;
          wdata_d      = req_wdata << {req_address[2:0], 3'b000};
          rd_en_d      = !req_write && !err_in;
          wr_en_d      = req_write && !err_in;
          state_d      = err_in ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = write_q ? RESP : CAPTURE;
      CAPTURE: begin
        case (be_q[1:0])
          2'b00:   rdata_d = {{56{ext}}, raw[7:0]};
          2'b01:   rdata_d = {{48{ext}}, raw[15:0]};
          2'b10:   rdata_d = {{32{ext}}, raw[31:0]};
          default: rdata_d = raw;
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      unsigned_q   <= unsigned_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = rdata_q;
  assign resp_misaligned = misaligned_q;
  assign resp_fault      = fault_q;
  assign mem_read_en     = rd_en_q;
  assign mem_write_en    = wr_en_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_write_data  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations are queued per request and
// checked against the response, latency and memory strobes.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [2:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_data_fetched;

  load_store_unit dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_misaligned  (resp_misaligned),
    .resp_fault       (resp_fault),
    .mem_read_en      (mem_read_en),
    .mem_write_en     (mem_write_en),
    .mem_byte_enable  (mem_byte_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_data_fetched (mem_data_fetched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    logic        flt;
    int          lat;
    int          n_rd;
    int          n_wr;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] mem_word;
  int          rd_cnt, wr_cnt, both_cnt;
  logic [63:0] last_wdata;
  logic [2:0]  last_be;
  logic [31:0] last_addr;

  // Memory model: returns mem_word the cycle after a read strobe, junk otherwise.
  always @(posedge clk)
    mem_data_fetched <= mem_read_en ? mem_word : 64'hA5A5_5A5A_C3C3_3C3C;

  always @(negedge clk) begin
    if (mem_read_en) begin
      rd_cnt++;
      last_addr = mem_address;
      last_be   = mem_byte_enable;
    end
    if (mem_write_en) begin
      wr_cnt++;
      last_addr  = mem_address;
      last_be    = mem_byte_enable;
      last_wdata = mem_write_data;
    end
    if (mem_read_en && mem_write_en) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [63:0] exp_rd, input logic mis,
                      input logic flt, input int lat, input int hold);
    exp_t e, got;
    int n;
    logic [63:0] s_rd;
    logic        s_mis, s_flt;
    e.rdata = exp_rd;
    e.mis   = mis;
    e.flt   = flt;
    e.lat   = lat;
    e.n_rd  = (!wr && !mis && !flt) ? 1 : 0;
    e.n_wr  = ( wr && !mis && !flt) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_wdata = wd;
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    s_rd = resp_rdata; s_mis = resp_misaligned; s_flt = resp_fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_rdata", resp_rdata, s_rd);
      check_eq("hold_flags", 64'({resp_misaligned, resp_fault}), 64'({s_mis, s_flt}));
      check_eq("hold_req_ready", 64'(req_ready), 64'd0);
    end
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check_eq("latency", 64'(n), 64'(got.lat));
      check_eq("resp_rdata", resp_rdata, got.rdata);
      check_eq("resp_misaligned", 64'(resp_misaligned), 64'(got.mis));
      check_eq("resp_fault", 64'(resp_fault), 64'(got.flt));
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check_eq("resp_valid_clear", 64'(resp_valid), 64'd0);
      check_eq("req_ready_back", 64'(req_ready), 64'd1);
      check_eq("rd_strobes", 64'(rd_cnt), 64'(got.n_rd));
      check_eq("wr_strobes", 64'(wr_cnt), 64'(got.n_wr));
      check_eq("strobe_overlap", 64'(both_cnt), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    check_eq({tag, "_resp_flags"}, 64'({resp_misaligned, resp_fault}), 64'd0);
    check_eq({tag, "_mem_strobes"}, 64'({mem_read_en, mem_write_en}), 64'd0);
    check_eq({tag, "_mem_be"}, 64'(mem_byte_enable), 64'd0);
    check_eq({tag, "_mem_addr"}, 64'(mem_address), 64'd0);
    check_eq({tag, "_mem_wdata"}, mem_write_data, 64'd0);
  endtask

  initial begin
    int vcnt;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = '0; req_wdata = '0; resp_ready = 1'b0;
    mem_word = 64'h1122_3344_8566_7788;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    last_wdata = '0; last_be = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    send(1'b0, 3'b000, 32'h0001_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF85, 1'b0, 1'b0, 3, 0);
    check_eq("lb_addr", 64'(last_addr), 64'h0001_0003);
    check_eq("lb_be", 64'(last_be), 64'd0);
    send(1'b0, 3'b101, 32'h0001_0004, 64'd0, 64'h0000_0000_0000_3344, 1'b0, 1'b0, 3, 0);
    check_eq("lhu_be", 64'(last_be), 64'd1);
    send(1'b1, 3'b010, 32'h0001_0004, 64'h0000_0000_DEAD_BEEF, 64'd0, 1'b0, 1'b0, 2, 0);
    check_eq("sw_wdata", last_wdata, 64'hDEAD_BEEF_0000_0000);
    check_eq("sw_be", 64'(last_be), 64'b010);
    send(1'b0, 3'b011, 32'h0001_0004, 64'd0, 64'd0, 1'b1, 1'b0, 1, 0);
    send(1'b0, 3'b010, 32'h0001_FFFE, 64'd0, 64'd0, 1'b1, 1'b1, 1, 0);
    send(1'b0, 3'b001, 32'h0001_FFFE, 64'd0, 64'h0000_0000_0000_1122, 1'b0, 1'b0, 3, 0);
    send(1'b0, 3'b000, 32'h0000_FFFF, 64'd0, 64'd0, 1'b0, 1'b1, 1, 0);
    send(1'b0, 3'b010, 32'hFFFF_FFFC, 64'd0, 64'd0, 1'b0, 1'b1, 1, 0);
    send(1'b0, 3'b010, 32'h0001_0000, 64'd0, 64'hFFFF_FFFF_8566_7788, 1'b0, 1'b0, 3, 5);
    send(1'b0, 3'b011, 32'h0001_FFF8, 64'd0, 64'h1122_3344_8566_7788, 1'b0, 1'b0, 3, 0);
    send(1'b1, 3'b100, 32'h0001_0005, 64'h0000_0000_0000_00AB, 64'd0, 1'b0, 1'b0, 2, 0);
    check_eq("sb_wdata", last_wdata, 64'h0000_AB00_0000_0000);
    check_eq("sb_be", 64'(last_be), 64'd0);
    send(1'b1, 3'b011, 32'h0001_FFF8, 64'h0102_0304_0506_0708, 64'd0, 1'b0, 1'b0, 2, 3);
    check_eq("sd_wdata", last_wdata, 64'h0102_0304_0506_0708);
    mem_word = 64'hF0E1_D2C3_B4A5_9687;
    send(1'b0, 3'b100, 32'h0001_0007, 64'd0, 64'h0000_0000_0000_00F0, 1'b0, 1'b0, 3, 0);
    send(1'b0, 3'b001, 32'h0001_0002, 64'd0, 64'hFFFF_FFFF_FFFF_B4A5, 1'b0, 1'b0, 3, 0);
    send(1'b0, 3'b110, 32'h0001_0004, 64'd0, 64'h0000_0000_F0E1_D2C3, 1'b0, 1'b0, 3, 0);

    // Reset while the access is in ISSUE: abandoned with no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0001_0008;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("issue_rd_en", 64'(mem_read_en), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) vcnt++;
    end
    check_eq("no_resp_after_rst", 64'(vcnt), 64'd0);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit sitting directly upstream of the data memory interface.
- Accepts one load or store request from the core's MEM stage per handshake.
- Checks alignment and data-region range, then drives the memory-side read/write strobes, address, size code and lane-shifted write data.
- Captures the returned 64-bit word, extracts the addressed lane, sign- or zero-extends it, and returns it to the core on a valid/ready response channel.

Parameters:
- DATA_BEGIN, 32'h0001_0000, first byte address of the data region (inclusive).
- DATA_END, 32'h0001_FFFF, last byte address of the data region (inclusive).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Bits [1:0] are the size: 00 = byte, 01 = half, 10 = word, 11 = double. Bit 2 = 1 means unsigned load; bit 2 is ignored for stores.
- req_address  in  32  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_misaligned  out  1  address not naturally aligned for the access size.
- resp_fault  out  1  access lies outside DATA_BEGIN..DATA_END.
- mem_read_en  out  1  read strobe to the data memory interface.
- mem_write_en  out  1  write strobe to the data memory interface.
- mem_byte_enable  out  3  {1'b0, size}; the downstream block is never asked to sign-extend.
- mem_address  out  32  registered request address, passed unchanged.
- mem_write_data  out  64  req_wdata shifted left by 8*address[2:0].
- mem_data_fetched  in  64  read data, valid the cycle after mem_read_en.

Behaviour:
- Reset values:
  - State = IDLE; req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_misaligned = 0, resp_fault = 0.
  - mem_read_en = 0, mem_write_en = 0, mem_byte_enable = 0, mem_address = 0, mem_write_data = 0.
- Reset asserted in any state returns the unit to IDLE next edge. An in-flight access is abandoned; no response is produced for it.
- Handshake:
  - A request is accepted on the edge where req_valid & req_ready; all request fields are registered on that edge.
  - A response completes on the edge where resp_valid & resp_ready.
  - resp_* outputs hold stable while resp_valid = 1 and resp_ready = 0.
- Alignment check: misaligned = (half & a[0]) | (word & a[1:0] != 0) | (double & a[2:0] != 0).
- Range check:
  - fault = start < DATA_BEGIN, or (start + bytes - 1) > DATA_END, where bytes = 1, 2, 4 or 8.
  - The end address is computed in 33 bits so no wrap occurs.
- When misaligned and fault are both set, both flags are reported. Either flag suppresses the memory access.
- States:
  - IDLE: req_ready = 1. On accept: go to RESP if the request errs; otherwise go to ISSUE.
  - ISSUE, one cycle: mem_read_en = !write, mem_write_en = write; mem_address, mem_byte_enable and mem_write_data are driven from the registers. Next state: CAPTURE for a load, RESP for a store.
  - CAPTURE, one cycle, loads only:
    - raw = mem_data_fetched >> (8*address[2:0]).
    - Keep the low 8/16/32/64 bits according to size.
    - Fill the upper bits with the lane MSB if funct3[2] = 0, otherwise with zeros. Double loads are unmodified.
    - Register the result into resp_rdata, then go to RESP.
  - RESP: resp_valid = 1. On resp_ready, go to IDLE and clear resp_valid.
- The mem strobes are high only in ISSUE, and for exactly one cycle per successful access. They are never both high.
- Latency, counted from the accept edge to first resp_valid:
  - Error: 1 cycle.
  - Store: 2 cycles.
  - Load: 3 cycles.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after the response handshake.

Test Plan:
- Signed byte load: address 0x0001_0003, funct3 000, memory word 0x1122_3344_8566_7788 → mem_read_en pulses once in ISSUE; resp_valid 3 cycles after accept; resp_rdata = 0xFFFF_FFFF_FFFF_FF85.
- Unsigned half load: address 0x0001_0004, funct3 101, same word → resp_rdata = 0x0000_0000_0000_3344.
- Word store: address 0x0001_0004, funct3 010, wdata 0xDEAD_BEEF → mem_write_en one cycle; mem_write_data = 0xDEAD_BEEF_0000_0000; mem_byte_enable = 3'b010; resp_valid 2 cycles after accept; resp_rdata = 0.
- Misaligned double: address 0x0001_0004, funct3 011 → no mem strobes; resp_misaligned = 1, resp_fault = 0 one cycle after accept.
- Fault on range edge: word load at DATA_END - 1 (0x0001_FFFE, aligned for half only) → misaligned = 1 and fault = 1. Half load at 0x0001_FFFE → no fault and normal completion.
- Backpressure and reset: hold resp_ready = 0 for 5 cycles → resp_* stable and req_ready = 0 throughout. Assert reset during ISSUE → next cycle IDLE, all outputs at reset values, no resp_valid.
